dma_burst_sched: RTL and testbench

//  Transfer-level scheduler upstream of the AXI4 master interface. Takes one DMA descriptor
//  (src, dst, beat count, size, inc modes) and splits it into AXI bursts. For each burst it

---
 rtl/dma_pkg.sv | 33 +++
 rtl/dma_burst_sched_if.sv | 34 +++
 rtl/dma_burst_calc.sv | 46 ++++
 rtl/dma_burst_sched.sv | 208 ++++++++++++++++++++
 tb/tb_dma_burst_sched.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA burst scheduler.
//   AXI_RESP_*      : BRESP encodings seen on write_resp
//   sched_status_t  : completion status reported alongside done
//   sched_state_t   : scheduler FSM states
//   beats_to_4k()   : beats that fit before the next 4KB boundary
package dma_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    StatOk      = 2'b00,
    StatSlvErr  = 2'b01,
    StatCfgErr  = 2'b10,
    StatAborted = 2'b11
  } sched_status_t;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StRdIss,
    StRdWait,
    StWrIss,
    StWrWait,
    StFin
  } sched_state_t;

  // Bytes left in the current 4KB page, expressed in beats of 1<<size bytes.
  function automatic logic [12:0] beats_to_4k(input logic [11:0] addr_lo, input logic [1:0] size);
    return (13'd4096 - {1'b0, addr_lo}) >> size;
  endfunction

endpackage

// File: rtl/dma_burst_sched_if.sv
// Command/response bundle between the burst scheduler and the AXI4 master engine.
//   master modport : scheduler side (issues burst commands, receives completions)
//   slave modport  : AXI master engine side
//   start_read_burst/start_write_burst : 1-cycle burst start pulses
//   read_addr/write_addr/burst_len/burst_size/src_inc/dst_inc : burst attributes
//   read_burst_done/write_burst_done/write_resp/mst_error     : completion feedback
interface dma_burst_sched_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              start_read_burst;
  logic              start_write_burst;
  logic [ADDR_W-1:0] read_addr;
  logic [ADDR_W-1:0] write_addr;
  logic [7:0]        burst_len;
  logic [1:0]        burst_size;
  logic              src_inc;
  logic              dst_inc;
  logic              read_burst_done;
  logic              write_burst_done;
  logic [1:0]        write_resp;
  logic              mst_error;

  modport master (
    output start_read_burst, start_write_burst, read_addr, write_addr,
           burst_len, burst_size, src_inc, dst_inc,
    input  read_burst_done, write_burst_done, write_resp, mst_error
  );

  modport slave (
    input  start_read_burst, start_write_burst, read_addr, write_addr,
           burst_len, burst_size, src_inc, dst_inc,
    output read_burst_done, write_burst_done, write_resp, mst_error
  );
endinterface

// File: rtl/dma_burst_calc.sv
// Combinational burst sizer: number of beats for the next burst.
//   beats_left        : beats still to transfer (never 0 when used)
//   src_addr/dst_addr : current burst addresses
//   size              : log2 bytes per beat
//   src_inc/dst_inc   : 1 = INCR side, subject to the 4KB rule
//   nb                : beats in next burst, 1..MAX_BEATS
// Config macro DMA_BOUNDARY_SPLIT_EN: when defined, bursts on INCR sides are
// also clipped so they never cross a 4KB boundary.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 16
) (
  input  logic [LEN_W-1:0]  beats_left,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [1:0]        size,
  input  logic              src_inc,
  input  logic              dst_inc,
  output logic [8:0]        nb
);

  logic [31:0] lim;

  always_comb begin
    lim = 32'(MAX_BEATS);
    if (32'(beats_left) < lim) lim = 32'(beats_left);
`ifdef DMA_BOUNDARY_SPLIT_EN
    if (src_inc && (32'(beats_to_4k(src_addr[11:0], size)) < lim)) begin
      lim = 32'(beats_to_4k(src_addr[11:0], size));
    end
    if (dst_inc && (32'(beats_to_4k(dst_addr[11:0], size)) < lim)) begin
      lim = 32'(beats_to_4k(dst_addr[11:0], size));
    end
`endif
  end

  assign nb = lim[8:0];

  // Bits that only matter in some configurations.
  logic unused_calc;
  assign unused_calc = ^{src_addr, dst_addr, size, src_inc, dst_inc, lim[31:9]};

endmodule

// File: rtl/dma_burst_sched.sv
// DMA burst scheduler: splits one descriptor into read/write AXI burst pairs.
//   aclk, aresetn         : clock, asynchronous active-low reset
//   cfg_start             : accept descriptor (only while idle)
//   cfg_abort             : stop after the current burst pair
//   cfg_src_addr/dst_addr : start addresses; cfg_beats: total beats
//   cfg_size              : log2 bytes/beat (3 illegal); cfg_src_inc/dst_inc: INCR flags
//   busy, done, status    : progress/completion; status valid with done
//   beats_left            : beats not yet written
//   bus (master modport)  : burst commands to / completions from the AXI master
// Config macro DMA_BOUNDARY_SPLIT_EN enables 4KB boundary splitting (see dma_burst_calc).
module dma_burst_sched
  import dma_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 16,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned LEN_W     = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                cfg_start,
  input  logic                cfg_abort,
  input  logic [ADDR_W-1:0]   cfg_src_addr,
  input  logic [ADDR_W-1:0]   cfg_dst_addr,
  input  logic [LEN_W-1:0]    cfg_beats,
  input  logic [1:0]          cfg_size,
  input  logic                cfg_src_inc,
  input  logic                cfg_dst_inc,
  output logic                busy,
  output logic                done,
  output logic [1:0]          status,
  output logic [LEN_W-1:0]    beats_left,
  dma_burst_sched_if.master   bus
);

  sched_state_t  state_q, state_d;
  sched_status_t status_q, status_d;
  logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_W-1:0]  left_q, left_d;
  logic [1:0]        size_q, size_d;
  logic              sinc_q, sinc_d, dinc_q, dinc_d;
  logic [8:0]        nb_q, nb_d;
  logic [7:0]        len_q, len_d;
  logic              abort_q, abort_d;
  logic              busy_q, done_q, rd_pulse_q, wr_pulse_q;

  logic [8:0] nb_calc;
  logic [2:0] align_mask;
  logic       cfg_err;

  dma_burst_calc #(
    .MAX_BEATS (MAX_BEATS),
    .ADDR_W    (ADDR_W),
    .LEN_W     (LEN_W)
  ) u_calc (
    .beats_left (left_q),
    .src_addr   (src_q),
    .dst_addr   (dst_q),
    .size       (size_q),
    .src_inc    (sinc_q),
    .dst_inc    (dinc_q),
    .nb         (nb_calc)
  );

  always_comb begin
    unique case (cfg_size)
      2'd0:    align_mask = 3'b000;
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
    cfg_err = (cfg_size == 2'b11) ||
              ((cfg_src_addr[2:0] & align_mask) != 3'b000) ||
              ((cfg_dst_addr[2:0] & align_mask) != 3'b000);
  end

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    src_d    = src_q;
    dst_d    = dst_q;
    left_d   = left_q;
    size_d   = size_q;
    sinc_d   = sinc_q;
    dinc_d   = dinc_q;
    nb_d     = nb_q;
    len_d    = len_q;
    // Abort is sticky for the rest of the descriptor once seen outside idle.
    abort_d  = abort_q | (cfg_abort & (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (cfg_start) begin
          src_d    = cfg_src_addr;
          dst_d    = cfg_dst_addr;
          left_d   = cfg_beats;
          size_d   = cfg_size;
          sinc_d   = cfg_src_inc;
          dinc_d   = cfg_dst_inc;
          abort_d  = 1'b0;
          status_d = StatOk;
          if (cfg_err) begin
            status_d = StatCfgErr;
            state_d  = StFin;
          end else if (cfg_beats == '0) begin
            state_d  = StFin;
          end else begin
            state_d  = StCalc;
          end
        end
      end
      StCalc: begin
        if (abort_q || cfg_abort) begin
          status_d = StatAborted;
          state_d  = StFin;
        end else begin
          nb_d    = nb_calc;
          len_d   = 8'(nb_calc - 9'd1);
          state_d = StRdIss;
        end
      end
      StRdIss: state_d = StRdWait;
      StRdWait: begin
        if (bus.read_burst_done) begin
          if (bus.mst_error) begin
            status_d = StatSlvErr;
            state_d  = StFin;
          end else begin
            state_d  = StWrIss;
          end
        end
      end
      StWrIss: state_d = StWrWait;
      StWrWait: begin
        if (bus.write_burst_done) begin
          left_d = left_q - LEN_W'(nb_q);
          if (sinc_q) src_d = src_q + (ADDR_W'(nb_q) << size_q);
          if (dinc_q) dst_d = dst_q + (ADDR_W'(nb_q) << size_q);
          if ((bus.write_resp != AXI_RESP_OKAY) || bus.mst_error) begin
            status_d = StatSlvErr;
            state_d  = StFin;
          end else if (abort_q || cfg_abort) begin
            status_d = StatAborted;
            state_d  = StFin;
          end else if (left_d == '0) begin
            status_d = StatOk;
            state_d  = StFin;
          end else begin
            state_d  = StCalc;
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      status_q   <= StatOk;
      src_q      <= '0;
      dst_q      <= '0;
      left_q     <= '0;
      size_q     <= 2'b10;
      sinc_q     <= 1'b0;
      dinc_q     <= 1'b0;
      nb_q       <= '0;
      len_q      <= '0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_pulse_q <= 1'b0;
      wr_pulse_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      status_q   <= status_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      left_q     <= left_d;
      size_q     <= size_d;
      sinc_q     <= sinc_d;
      dinc_q     <= dinc_d;
      nb_q       <= nb_d;
      len_q      <= len_d;
      abort_q    <= abort_d;
      // Pulses are registered one cycle behind their state so every output is a flop.
      busy_q     <= (state_d != StIdle);
      done_q     <= (state_q == StFin);
      rd_pulse_q <= (state_q == StRdIss);
      wr_pulse_q <= (state_q == StWrIss);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign status     = status_q;
  assign beats_left = left_q;

  assign bus.start_read_burst  = rd_pulse_q;
  assign bus.start_write_burst = wr_pulse_q;
  assign bus.read_addr         = src_q;
  assign bus.write_addr        = dst_q;
  assign bus.burst_len         = len_q;
  assign bus.burst_size        = size_q;
  assign bus.src_inc           = sinc_q;
  assign bus.dst_inc           = dinc_q;

endmodule

// File: tb/tb_dma_burst_sched.sv
// Bench for dma_burst_sched: table of descriptors run against a small responder
// that acknowledges each burst two cycles after its start pulse, plus hand-written
// reset sequences. Works with or without DMA_BOUNDARY_SPLIT_EN.
module tb_dma_burst_sched;

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] beats;
    logic [1:0]  size;
    logic        sinc;
    logic        dinc;
    int          err_at;    // write burst index answered with SLVERR, -1 none
    int          abort_at;  // read burst index to abort in, -2 = in first CALC, -1 none
    int          mst_at;    // read burst index completing with mst_error, -1 none
    int          exp_n;     // read bursts expected
    int          exp_w;     // write bursts expected
    logic [7:0]  len0;
    logic [7:0]  len1;
    logic [7:0]  lenl;
    logic [31:0] raddr1;
    logic [1:0]  status;
    logic [15:0] left;
    logic [31:0] fsrc;
    logic [31:0] fdst;
    int          done_k;    // cycles start->done, 0 = unchecked
  } vec_t;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cfg_start, cfg_abort, cfg_src_inc, cfg_dst_inc;
  logic [31:0] cfg_src_addr, cfg_dst_addr;
  logic [15:0] cfg_beats;
  logic [1:0]  cfg_size;
  logic        busy, done;
  logic [1:0]  status;
  logic [15:0] beats_left;

  int checks   = 0;
  int failures = 0;

  dma_burst_sched_if #(.ADDR_W(32)) bus ();

  dma_burst_sched #(
    .MAX_BEATS (16),
    .ADDR_W    (32),
    .LEN_W     (16)
  ) dut (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .cfg_start    (cfg_start),
    .cfg_abort    (cfg_abort),
    .cfg_src_addr (cfg_src_addr),
    .cfg_dst_addr (cfg_dst_addr),
    .cfg_beats    (cfg_beats),
    .cfg_size     (cfg_size),
    .cfg_src_inc  (cfg_src_inc),
    .cfg_dst_inc  (cfg_dst_inc),
    .busy         (busy),
    .done         (done),
    .status       (status),
    .beats_left   (beats_left),
    .bus          (bus)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    bus.read_burst_done = 1'b0; bus.write_burst_done = 1'b0;
    bus.write_resp = 2'b00; bus.mst_error = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int rd_cd, wr_cd, rd_idx, wr_idx, nr, nw, done_k, first_rd_k;
    logic [7:0]  lens[16];
    logic [31:0] raddr[16];
    bit fin;
    rd_cd = 0; wr_cd = 0; rd_idx = 0; wr_idx = 0; nr = 0; nw = 0;
    done_k = 0; first_rd_k = 0; fin = 1'b0;
    for (int j = 0; j < 16; j++) begin lens[j] = '0; raddr[j] = '0; end

    @(negedge aclk);
    cfg_src_addr = v.src; cfg_dst_addr = v.dst; cfg_beats = v.beats;
    cfg_size = v.size; cfg_src_inc = v.sinc; cfg_dst_inc = v.dinc;
    cfg_start = 1'b1;

    for (int k = 1; k <= 400 && !fin; k++) begin
      @(negedge aclk);
      idle_inputs();
      // Descriptor inputs change after acceptance; the DUT must have latched them.
      cfg_src_addr = 32'hDEAD_BEE0; cfg_dst_addr = 32'h0BAD_F000; cfg_beats = 16'd1;
      cfg_size = 2'd0; cfg_src_inc = ~v.sinc; cfg_dst_inc = ~v.dinc;
      if (k == 1) begin
        chk($sformatf("v%0d busy_after_start", i), 32'(busy), 32'd1);
        if (v.abort_at == -2) cfg_abort = 1'b1;
      end
      if (done) begin
        fin = 1'b1;
        done_k = k;
        chk($sformatf("v%0d status", i), 32'(status), 32'(v.status));
        chk($sformatf("v%0d beats_left", i), 32'(beats_left), 32'(v.left));
        chk($sformatf("v%0d final_read_addr", i), bus.read_addr, v.fsrc);
        chk($sformatf("v%0d final_write_addr", i), bus.write_addr, v.fdst);
        chk($sformatf("v%0d busy_at_done", i), 32'(busy), 32'd0);
      end else begin
        if (k == 5) cfg_start = 1'b1;  // must be ignored while busy
        if (rd_cd > 0) begin
          rd_cd--;
          if (rd_cd == 0) begin
            bus.read_burst_done = 1'b1;
            if (rd_idx == v.mst_at) bus.mst_error = 1'b1;
          end
        end
        if (wr_cd > 0) begin
          wr_cd--;
          if (wr_cd == 0) begin
            bus.write_burst_done = 1'b1;
            bus.write_resp = (wr_idx == v.err_at) ? 2'b10 : 2'b00;
          end
        end
        if (bus.start_read_burst) begin
          if (nr < 16) begin lens[nr] = bus.burst_len; raddr[nr] = bus.read_addr; end
          if (nr == 0) first_rd_k = k;
          rd_idx = nr;
          if (nr == v.abort_at) cfg_abort = 1'b1;
          nr++;
          rd_cd = 2;
        end
        if (bus.start_write_burst) begin
          wr_idx = nw;
          nw++;
          wr_cd = 2;
        end
      end
    end

    if (!fin) begin
      checks++;
      failures++;
      $display("FAIL v%0d timeout: done not seen within 400 cycles, expected a done pulse", i);
    end
    chk($sformatf("v%0d read_bursts", i), 32'(nr), 32'(v.exp_n));
    chk($sformatf("v%0d write_bursts", i), 32'(nw), 32'(v.exp_w));
    if (v.done_k != 0) chk($sformatf("v%0d done_latency", i), 32'(done_k), 32'(v.done_k));
    if (v.exp_n >= 1) begin
      chk($sformatf("v%0d read_latency", i), 32'(first_rd_k), 32'd3);
      chk($sformatf("v%0d len0", i), 32'(lens[0]), 32'(v.len0));
      chk($sformatf("v%0d len_last", i), 32'(lens[(nr > 0) ? nr - 1 : 0]), 32'(v.lenl));
    end
    if (v.exp_n >= 2) begin
      chk($sformatf("v%0d len1", i), 32'(lens[1]), 32'(v.len1));
      chk($sformatf("v%0d raddr1", i), raddr[1], v.raddr1);
    end
    @(negedge aclk);
    chk($sformatf("v%0d done_one_cycle", i), 32'(done), 32'd0);
    cfg_start = 1'b0;
  endtask

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{32'h1000, 32'h2000, 16'd40, 2'd2, 1'b1, 1'b1, -1, -1, -1, 3, 3,
                 8'd15, 8'd15, 8'd7, 32'h1040, 2'b00, 16'd0, 32'h10A0, 32'h20A0, 0};
`ifdef DMA_BOUNDARY_SPLIT_EN
    vecs[1]  = '{32'h1FF0, 32'h3000, 16'd16, 2'd2, 1'b1, 1'b1, -1, -1, -1, 2, 2,
                 8'd3, 8'd11, 8'd11, 32'h2000, 2'b00, 16'd0, 32'h2030, 32'h3040, 0};
`else
    vecs[1]  = '{32'h1FF0, 32'h3000, 16'd16, 2'd2, 1'b1, 1'b1, -1, -1, -1, 1, 1,
                 8'd15, 8'd0, 8'd15, 32'h0, 2'b00, 16'd0, 32'h2030, 32'h3040, 0};
`endif
    vecs[2]  = '{32'h4000, 32'h5000, 16'd0, 2'd2, 1'b1, 1'b1, -1, -1, -1, 0, 0,
                 8'd0, 8'd0, 8'd0, 32'h0, 2'b00, 16'd0, 32'h4000, 32'h5000, 2};
    vecs[3]  = '{32'h1002, 32'h2000, 16'd8, 2'd2, 1'b1, 1'b1, -1, -1, -1, 0, 0,
                 8'd0, 8'd0, 8'd0, 32'h0, 2'b10, 16'd8, 32'h1002, 32'h2000, 2};
    vecs[4]  = '{32'h1000, 32'h2000, 16'd40, 2'd2, 1'b1, 1'b1, 0, -1, -1, 1, 1,
                 8'd15, 8'd0, 8'd15, 32'h0, 2'b01, 16'd24, 32'h1040, 32'h2040, 0};
    vecs[5]  = '{32'h1000, 32'h2000, 16'd40, 2'd2, 1'b1, 1'b1, -1, 0, -1, 1, 1,
                 8'd15, 8'd0, 8'd15, 32'h0, 2'b11, 16'd24, 32'h1040, 32'h2040, 0};
    vecs[6]  = '{32'h5003, 32'h6000, 16'd20, 2'd0, 1'b0, 1'b1, -1, -1, -1, 2, 2,
                 8'd15, 8'd3, 8'd3, 32'h5003, 2'b00, 16'd0, 32'h5003, 32'h6014, 0};
    vecs[7]  = '{32'h0, 32'h0, 16'd4, 2'd3, 1'b1, 1'b1, -1, -1, -1, 0, 0,
                 8'd0, 8'd0, 8'd0, 32'h0, 2'b10, 16'd4, 32'h0, 32'h0, 2};
    vecs[8]  = '{32'h100, 32'h200, 16'd17, 2'd1, 1'b1, 1'b1, -1, -1, -1, 2, 2,
                 8'd15, 8'd0, 8'd0, 32'h120, 2'b00, 16'd0, 32'h122, 32'h222, 0};
    vecs[9]  = '{32'h1000, 32'h2000, 16'd40, 2'd2, 1'b1, 1'b1, -1, -2, -1, 0, 0,
                 8'd0, 8'd0, 8'd0, 32'h0, 2'b11, 16'd40, 32'h1000, 32'h2000, 3};
    vecs[10] = '{32'h2000, 32'h2001, 16'd4, 2'd1, 1'b1, 1'b1, -1, -1, -1, 0, 0,
                 8'd0, 8'd0, 8'd0, 32'h0, 2'b10, 16'd4, 32'h2000, 32'h2001, 2};
    vecs[11] = '{32'h1000, 32'h2000, 16'd40, 2'd2, 1'b1, 1'b1, -1, -1, 1, 2, 1,
                 8'd15, 8'd15, 8'd15, 32'h1040, 2'b01, 16'd24, 32'h1040, 32'h2040, 0};

    aresetn = 1'b0;
    idle_inputs();
    cfg_src_addr = '0; cfg_dst_addr = '0; cfg_beats = '0;
    cfg_size = '0; cfg_src_inc = 1'b0; cfg_dst_inc = 1'b0;
    repeat (3) @(negedge aclk);

    // Reset state.
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst status", 32'(status), 32'd0);
    chk("rst beats_left", 32'(beats_left), 32'd0);
    chk("rst start_rd", 32'(bus.start_read_burst), 32'd0);
    chk("rst start_wr", 32'(bus.start_write_burst), 32'd0);
    chk("rst read_addr", bus.read_addr, 32'd0);
    chk("rst burst_len", 32'(bus.burst_len), 32'd0);
    chk("rst burst_size", 32'(bus.burst_size), 32'd2);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

    // Reset in the middle of WR_WAIT: everything clears at once, no done pulse.
    begin
      bit seen;
      seen = 1'b0;
      @(negedge aclk);
      cfg_src_addr = 32'h1000; cfg_dst_addr = 32'h2000; cfg_beats = 16'd48;
      cfg_size = 2'd2; cfg_src_inc = 1'b1; cfg_dst_inc = 1'b1; cfg_start = 1'b1;
      for (int k = 0; k < 50 && !seen; k++) begin
        @(negedge aclk);
        idle_inputs();
        if (bus.start_read_burst) begin
          @(negedge aclk); @(negedge aclk);
          bus.read_burst_done = 1'b1;
          @(negedge aclk);
          bus.read_burst_done = 1'b0;
        end
        if (bus.start_write_burst) seen = 1'b1;
      end
      chk("mid_rst reached_write", 32'(seen), 32'd1);
      #1 aresetn = 1'b0;
      #1;
      chk("mid_rst busy", 32'(busy), 32'd0);
      chk("mid_rst start_wr", 32'(bus.start_write_burst), 32'd0);
      chk("mid_rst read_addr", bus.read_addr, 32'd0);
      chk("mid_rst write_addr", bus.write_addr, 32'd0);
      chk("mid_rst beats_left", 32'(beats_left), 32'd0);
      chk("mid_rst burst_len", 32'(bus.burst_len), 32'd0);
      chk("mid_rst burst_size", 32'(bus.burst_size), 32'd2);
      chk("mid_rst status", 32'(status), 32'd0);
      @(negedge aclk);
      aresetn = 1'b1;
      bus.write_burst_done = 1'b1;  // stale completion while idle must be ignored
      begin
        int dones;
        dones = 0;
        for (int k = 0; k < 6; k++) begin
          @(negedge aclk);
          bus.write_burst_done = 1'b0;
          if (done || busy) dones++;
        end
        chk("mid_rst no_done_after", 32'(dones), 32'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
